// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   FIFO_WIDTH / FIFO_DEPTH : default word width and entry count
//   fifo_status_t           : bundle of the FIFO status and event flags
//   clog2_depth()           : address width needed to index a given depth
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
    logic wr_ack;
  } fifo_status_t;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < depth; i = i * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one
// combinational read port. Contents are not reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
module fifo_mem_2p import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  localparam int unsigned AW        = clog2_depth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and sticky error flag.
// FWFT=0 gives a registered read (1-cycle latency); FWFT=1 presents the head
// word combinationally.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en, rd_en, flush   : write request, read/pop request, synchronous clear
//   data_in / data_out    : write data / read data
//   data_valid            : data_out holds a valid word
//   wr_ack/overflow/underflow : registered per-cycle write/read outcome
//   full/empty/almostfull/almostempty/count : occupancy status
//   err_sticky            : set on overflow/underflow, cleared by flush/reset
module fifo_sync_prog import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned AW        = clog2_depth(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count,
  output logic                  err_sticky
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("fifo_sync_prog: DEPTH must be a power of 2 and >= 2");
  end
  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
    $error("fifo_sync_prog: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (FWFT > 1) begin : g_chk_fwft
    $error("fifo_sync_prog: FWFT must be 0 or 1");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  wr_acc, rd_acc, wr_rej, rd_rej;
  logic                  wr_ack_q, ovf_q, udf_q, err_q;
  logic [DATA_WIDTH-1:0] mem_rd;
  fifo_status_t          status;

  always_comb begin
    status             = '0;
    status.full        = (cnt == CW'(DEPTH));
    status.empty       = (cnt == '0);
    status.almostfull  = (cnt >= CW'(AF_THRESH));
    status.almostempty = (cnt <= CW'(AE_THRESH));
    status.overflow    = ovf_q;
    status.underflow   = udf_q;
    status.wr_ack      = wr_ack_q;
  end

  // Accept/reject decided on pre-edge state; flush suppresses all outcomes.
  assign wr_acc = wr_en & ~status.full  & ~flush;
  assign rd_acc = rd_en & ~status.empty & ~flush;
  assign wr_rej = wr_en &  status.full  & ~flush;
  assign rd_rej = rd_en &  status.empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ack_q <= wr_acc;
      ovf_q    <= wr_rej;
      udf_q    <= rd_rej;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        err_q  <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        if (wr_acc && !rd_acc)      cnt <= cnt + 1'b1;
        else if (!wr_acc && rd_acc) cnt <= cnt - 1'b1;
        if (wr_rej || rd_rej) err_q <= 1'b1;
      end
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc;
        if (rd_acc) dout_q <= mem_rd;
      end
    end
    assign data_out   = dout_q;
    assign data_valid = dv_q;
  end else begin : g_fwft
    // Head word is visible as soon as count shows it present.
    assign data_out   = mem_rd;
    assign data_valid = ~status.empty;
  end

  assign full        = status.full;
  assign empty       = status.empty;
  assign almostfull  = status.almostfull;
  assign almostempty = status.almostempty;
  assign wr_ack      = status.wr_ack;
  assign overflow    = status.overflow;
  assign underflow   = status.underflow;
  assign count       = cnt;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: a standard-read instance and a
// FWFT instance, both checked against queue-based reference models.
module tb_fifo_sync_prog;

  localparam int DW = 16;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dv, ack, ovf, udf, full, empty, af, ae, err;
  logic [3:0]    cnt;

  logic          f_wr = 1'b0, f_rd = 1'b0, f_flush = 1'b0;
  logic [DW-1:0] f_din = '0;
  logic [DW-1:0] f_dout;
  logic          f_dv, f_ack, f_ovf, f_udf, f_full, f_empty, f_af, f_ae, f_err;
  logic [3:0]    f_cnt;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_in(din), .data_out(dout), .data_valid(dv), .wr_ack(ack),
    .overflow(ovf), .underflow(udf), .full(full), .empty(empty),
    .almostfull(af), .almostempty(ae), .count(cnt), .err_sticky(err));

  fifo_sync_prog #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(7), .AE_THRESH(1), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .rd_en(f_rd), .flush(f_flush),
    .data_in(f_din), .data_out(f_dout), .data_valid(f_dv), .wr_ack(f_ack),
    .overflow(f_ovf), .underflow(f_udf), .full(f_full), .empty(f_empty),
    .almostfull(f_af), .almostempty(f_ae), .count(f_cnt), .err_sticky(f_err));

  int    total = 0, passed = 0, failed = 0;
  string phase = "init";

  // Reference model state: queue contents plus last-cycle outcomes.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_dv = 0, m_ack = 0, m_ovf = 0, m_udf = 0, m_err = 0;
  logic [DW-1:0] fq[$];
  bit            fm_ack = 0, fm_ovf = 0, fm_udf = 0, fm_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_main();
    int n;
    n = q.size();
    chk("count", 32'(cnt), n);
    chk("full", 32'(full), 32'(n == DP));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almostfull", 32'(af), 32'(n >= 7));
    chk("almostempty", 32'(ae), 32'(n <= 1));
    chk("wr_ack", 32'(ack), 32'(m_ack));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(udf), 32'(m_udf));
    chk("err_sticky", 32'(err), 32'(m_err));
    chk("data_valid", 32'(dv), 32'(m_dv));
    chk("data_out", 32'(dout), 32'(m_dout));
  endtask

  task automatic check_fwft();
    int n;
    n = fq.size();
    chk("f_count", 32'(f_cnt), n);
    chk("f_full", 32'(f_full), 32'(n == DP));
    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("f_almostfull", 32'(f_af), 32'(n >= 7));
    chk("f_almostempty", 32'(f_ae), 32'(n <= 1));
    chk("f_wr_ack", 32'(f_ack), 32'(fm_ack));
    chk("f_overflow", 32'(f_ovf), 32'(fm_ovf));
    chk("f_underflow", 32'(f_udf), 32'(fm_udf));
    chk("f_err_sticky", 32'(f_err), 32'(fm_err));
    chk("f_data_valid", 32'(f_dv), 32'(n != 0));
    if (n != 0) chk("f_data_out", 32'(f_dout), 32'(fq[0]));
  endtask

  // One clock of the standard instance: drive at negedge, check 1ns after posedge.
  task automatic step(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
    bit pf, pe, wa, ra;
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; din = d;
    @(posedge clk); #1;
    pf = (q.size() == DP);
    pe = (q.size() == 0);
    wa = w && !pf && !f;
    ra = r && !pe && !f;
    m_ack = wa;
    m_ovf = w && pf && !f;
    m_udf = r && pe && !f;
    m_dv  = ra;
    if (f) begin
      q.delete();
      m_err = 0;
    end else begin
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      if (m_ovf || m_udf) m_err = 1;
    end
    check_main();
  endtask

  task automatic fstep(input bit w, input bit r, input logic [DW-1:0] d);
    bit pf, pe, wa, ra;
    @(negedge clk);
    f_wr = w; f_rd = r; f_din = d;
    @(posedge clk); #1;
    pf = (fq.size() == DP);
    pe = (fq.size() == 0);
    wa = w && !pf;
    ra = r && !pe;
    fm_ack = wa;
    fm_ovf = w && pf;
    fm_udf = r && pe;
    if (ra) void'(fq.pop_front());
    if (wa) fq.push_back(d);
    if (fm_ovf || fm_udf) fm_err = 1;
    check_fwft();
  endtask

  task automatic model_reset();
    q.delete();
    fq.delete();
    m_dout = '0;
    m_dv = 0; m_ack = 0; m_ovf = 0; m_udf = 0; m_err = 0;
    fm_ack = 0; fm_ovf = 0; fm_udf = 0; fm_err = 0;
  endtask

  initial begin
    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_main();
    check_fwft();
    @(negedge clk);
    rst_n = 1'b1;

    phase = "fill";
    for (int i = 1; i <= 9; i++) step(1, 0, 0, DW'(i));

    phase = "drain";
    for (int i = 0; i < 9; i++) step(0, 1, 0, '0);

    phase = "simul_full";
    for (int i = 0; i < 8; i++) step(1, 0, 0, DW'(16'h00F0 + i));
    step(1, 1, 0, 16'hAAAA);
    for (int i = 0; i < 7; i++) step(0, 1, 0, '0);

    phase = "simul_empty";
    step(1, 1, 0, 16'h5555);
    step(0, 1, 0, '0);

    phase = "simul_half";
    for (int i = 0; i < 4; i++) step(1, 0, 0, DW'(16'h0100 + i));
    for (int i = 0; i < 5; i++) step(1, 1, 0, DW'($urandom));
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0);

    phase = "wrap";
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'($urandom));
    for (int i = 0; i < 100; i++) step(1, 1, 0, DW'($urandom));

    phase = "random";
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), DW'($urandom));

    phase = "flush";
    for (int i = 0; i < 9; i++) step(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(16'h0200 + i));
    step(1, 0, 1, 16'hBEEF);
    step(1, 0, 0, 16'h0300);
    step(1, 0, 0, 16'h0301);

    phase = "async_reset";
    @(negedge clk);
    wr_en = 0; rd_en = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_main();
    check_fwft();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, DW'(16'h0400 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);

    phase = "fwft";
    fstep(1, 0, 16'h1234);
    chk("fwft_first_word", 32'(f_dout), 32'h1234);
    fstep(0, 1, '0);
    chk("fwft_empty_after_pop", 32'(f_empty), 32'h1);
    for (int i = 0; i < 80; i++) fstep(1'($urandom), 1'($urandom), DW'($urandom));
    for (int i = 0; i < 9; i++) fstep(0, 1, '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
